adc_init_seq: RTL and testbench
===============================

# adc_init_seq

Serial configuration sequencer for the front-end ADCs. It responds to the power-on reset sequencer's ADC init handshake. While `ADC_INIT_RST` is high the block is held idle. Once reset is released it waits a power-settle delay, then shifts a fixed table of 24-bit configuration words to the ADCs over a 3-wire serial bus. When the table is done it asserts `ADC_RDY`, which moves the reset sequencer into its run state.

## Interface
Parameters:
- `NWORDS`, 8: number of configuration words sent, 1..16.
- `SCLK_DIV`, 4: CLK cycles per SCLK half-period, at least 2.
- `PWR_DLY`, 1000: CLK cycles waited after reset release before the first word, at least 1.

Ports:
- `CLK` in 1: system clock; all logic is on its rising edge.
- `ADC_INIT_RST` in 1: asynchronous, active-high reset, driven by the power-on reset sequencer.
- `RESTART` in 1: synchronous one-cycle pulse that re-runs the whole sequence.
- `ADC_RDY` out 1: high when the configuration is complete.
- `ADC_CSB` out 1: active-low chip select, broadcast to all ADCs.
- `ADC_SCLK` out 1: serial clock.
- `ADC_SDATA` out 1: serial data, MSB first.
- `ADC_INIT_STATE` out 3: current state encoding, for diagnostics.

## Operation
Reset values, all registered: `ADC_RDY`=0, `ADC_CSB`=1, `ADC_SCLK`=0, `ADC_SDATA`=0, state=Pwr_Wait, word index=0, delay counter=0.

States:
- **Pwr_Wait**
  - Counts `PWR_DLY` cycles, then goes to Load.
- **Load** (1 cycle)
  - Shift register takes ROM word[idx].
  - `ADC_CSB` goes to 0; `ADC_SDATA` takes bit 23; `ADC_SCLK` stays 0.
  - Then goes to Shift.
- **Shift**
  - Half-period counter runs 0..`SCLK_DIV`-1. At each wrap `ADC_SCLK` toggles.
  - On the rising toggle the ADC samples `ADC_SDATA`.
  - On each falling toggle the shift register moves left and `ADC_SDATA` takes the next bit.
  - A bit counter counts rising edges. After the 24th rising edge, the next falling-edge wrap goes to Gap with `ADC_SCLK`=0.
- **Gap**
  - `ADC_CSB`=1 and `ADC_SDATA`=0 for 2·`SCLK_DIV` cycles.
  - If idx = `NWORDS`-1, go to Done. Otherwise idx+1, go to Load.
- **Done**
  - `ADC_RDY`=1, bus idle (`ADC_CSB`=1, `ADC_SCLK`=0, `ADC_SDATA`=0).
  - Stays here until reset or `RESTART`.

Boundary and interaction rules:
- **`RESTART` in any state:**
  - Next cycle: `ADC_RDY`=0, `ADC_CSB`=1, `ADC_SCLK`=0, `ADC_SDATA`=0, idx=0, counters cleared, state=Pwr_Wait.
  - A word aborted mid-shift is discarded; the ADC ignores frames shorter than 24 bits.
- **`ADC_INIT_RST` asserted mid-operation:** outputs take their reset values immediately (asynchronous), including `ADC_RDY`=0.
- **`RESTART` and reset released in the same cycle:** same result as reset alone.
- **Counter widths:** idx is 4 bits; the bit counter is 5 bits; delay and half-period counters are sized by `$clog2`. No counter wraps in normal operation.

## Timing
- One word takes 1 + 50·`SCLK_DIV` CLK cycles: Load, then 48 half-periods, then a 2-half-period Gap.
- `ADC_RDY` rises on rising edge number `PWR_DLY` + `NWORDS`·(1 + 50·`SCLK_DIV`), counted from the first edge after `ADC_INIT_RST` falls. Defaults give 1000 + 8·201 = 2608.
- Setup and hold at the ADC: `ADC_SDATA` is stable for `SCLK_DIV` cycles before and after every rising `ADC_SCLK` edge.
- `ADC_CSB` falls `SCLK_DIV`+1 cycles before the first rising edge. It rises `SCLK_DIV` cycles after the last rising edge.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Structure
- **Package `adc_init_pkg`:**
  - State encoding: Pwr_Wait=3'd0, Load=3'd1, Shift=3'd2, Gap=3'd3, Done=3'd4.
  - Constant `ADC_WORD_W`=24.
  - Constant table `ADC_INIT_WORDS[0:15]`. Word 0 = 24'h000001 (software reset); word 1 = 24'h0D0000.
- **Sub-module `adc_init_rom`:** combinational index-to-word lookup over the package table, 4-bit index, 24-bit word.
- Everything else lives in the single top module.

## Test plan
Bench parameters unless stated: `PWR_DLY`=16, `SCLK_DIV`=2, `NWORDS`=4.

1. **Full sequence:** release reset.
   - `ADC_RDY` rises on edge 16 + 4·101 = 420.
   - Exactly 4 `ADC_CSB`-low frames occur, each with 24 `ADC_SCLK` rising edges.
2. **Frame content:** capture `ADC_SDATA` on each rising `ADC_SCLK`.
   - Frame 0 reads 24'h000001; frame 1 reads 24'h0D0000.
   - `ADC_SDATA` never changes within 2 cycles of a rising edge.
3. **Abort:** pulse `RESTART` during the 10th bit of frame 2.
   - Next cycle: `ADC_CSB`=1, `ADC_SCLK`=0.
   - `ADC_RDY` then rises 420 edges after the pulse.
   - The captured frame count is 2 complete frames + 1 partial + 4 complete.
4. **Restart from Done:** pulse `RESTART` while `ADC_RDY`=1.
   - `ADC_RDY`=0 next cycle; `ADC_INIT_STATE`=0.
   - The sequence repeats identically.
5. **Asynchronous reset:** assert `ADC_INIT_RST` between clock edges mid-Shift.
   - All outputs reach reset values before the next edge.
   - No partial frame continues after release.
6. **Corner parameters:** `NWORDS`=1, `SCLK_DIV`=2.
   - `ADC_RDY` rises on edge 16 + 101 = 117.
   - Only word 0 is sent.

Source files
------------

// File: rtl/adc_init_pkg.sv
// Shared types and constants for the ADC serial configuration sequencer:
// state encoding, configuration word width and the configuration word table.
package adc_init_pkg;

    localparam int ADC_WORD_W = 24;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_GAP      = 3'd3,
        ST_DONE     = 3'd4
    } adc_state_t;

    // Word 0 is the ADC software reset, so it must always go out first.
    localparam logic [ADC_WORD_W-1:0] ADC_INIT_WORDS [0:15] = '{
        24'h000001, 24'h0D0000, 24'h140041, 24'h160080,
        24'h0F0100, 24'h100000, 24'h180002, 24'h210003,
        24'h000000, 24'h000000, 24'h000000, 24'h000000,
        24'h000000, 24'h000000, 24'h000000, 24'h000000
    };

endpackage

// File: rtl/adc_init_rom.sv
// Combinational index-to-word lookup over the configuration word table.
// Zero latency, no flow control.
module adc_init_rom
    import adc_init_pkg::*;
(
    input  logic [3:0]            idx,
    output logic [ADC_WORD_W-1:0] word
);

    assign word = ADC_INIT_WORDS[idx];

endmodule

// File: rtl/adc_init_seq.sv
// Power-settle delay, then shifts NWORDS 24-bit words MSB first over CSB/SCLK/SDATA,
// then raises ADC_RDY. All outputs are registered; RESTART re-runs the whole sequence.
module adc_init_seq
    import adc_init_pkg::*;
#(
    parameter int NWORDS   = 8,
    parameter int SCLK_DIV = 4,
    parameter int PWR_DLY  = 1000
) (
    input  logic       CLK,
    input  logic       ADC_INIT_RST,
    input  logic       RESTART,
    output logic       ADC_RDY,
    output logic       ADC_CSB,
    output logic       ADC_SCLK,
    output logic       ADC_SDATA,
    output logic [2:0] ADC_INIT_STATE
);

    localparam int DW = $clog2(PWR_DLY + 1);
    localparam int HW = $clog2(2 * SCLK_DIV);
    localparam logic [DW-1:0] DLY_LAST = DW'(PWR_DLY - 1);
    localparam logic [HW-1:0] HC_LAST  = HW'(SCLK_DIV - 1);
    localparam logic [HW-1:0] GAP_LAST = HW'(2 * SCLK_DIV - 1);
    localparam logic [3:0]    IDX_LAST = 4'(NWORDS - 1);

    adc_state_t state_q, state_d;
    logic [3:0]            idx_q, idx_d;
    logic [DW-1:0]         dly_q, dly_d;
    logic [HW-1:0]         hc_q, hc_d;
    logic [4:0]            bit_q, bit_d;
    // Holds only the bits not yet on ADC_SDATA; the MSB lives in the output flop.
    logic [ADC_WORD_W-2:0] sr_q, sr_d;
    logic                  rdy_q, rdy_d;
    logic                  csb_q, csb_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, sdata_d;
    logic [ADC_WORD_W-1:0] rom_word;

    adc_init_rom u_rom (
        .idx  (idx_q),
        .word (rom_word)
    );

    always_ff @(posedge CLK or posedge ADC_INIT_RST) begin
        if (ADC_INIT_RST) begin
            state_q <= ST_PWR_WAIT;
            idx_q   <= '0;
            dly_q   <= '0;
            hc_q    <= '0;
            bit_q   <= '0;
            sr_q    <= '0;
            rdy_q   <= 1'b0;
            csb_q   <= 1'b1;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            dly_q   <= dly_d;
            hc_q    <= hc_d;
            bit_q   <= bit_d;
            sr_q    <= sr_d;
            rdy_q   <= rdy_d;
            csb_q   <= csb_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
        hc_d    = hc_q;
        bit_d   = bit_q;
        sr_d    = sr_q;
        rdy_d   = rdy_q;
        csb_d   = csb_q;
        sclk_d  = sclk_q;
        sdata_d = sdata_q;
        if (RESTART) begin
            state_d = ST_PWR_WAIT;
            idx_d   = '0;
            dly_d   = '0;
            hc_d    = '0;
            bit_d   = '0;
            rdy_d   = 1'b0;
            csb_d   = 1'b1;
            sclk_d  = 1'b0;
            sdata_d = 1'b0;
        end else begin
            case (state_q)
                ST_PWR_WAIT: begin
                    if (dly_q == DLY_LAST) begin
                        dly_d   = '0;
                        csb_d   = 1'b0;
                        state_d = ST_LOAD;
                    end else begin
                        dly_d = dly_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    sr_d    = rom_word[ADC_WORD_W-2:0];
                    sdata_d = rom_word[ADC_WORD_W-1];
                    hc_d    = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (hc_q == HC_LAST) begin
                        hc_d = '0;
                        if (!sclk_q) begin
                            sclk_d = 1'b1;
                            bit_d  = bit_q + 1'b1;
                        end else if (bit_q == 5'd24) begin
                            sclk_d  = 1'b0;
                            csb_d   = 1'b1;
                            sdata_d = 1'b0;
                            state_d = ST_GAP;
                        end else begin
                            sclk_d  = 1'b0;
                            sdata_d = sr_q[ADC_WORD_W-2];
                            sr_d    = {sr_q[ADC_WORD_W-3:0], 1'b0};
                        end
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (hc_q == GAP_LAST) begin
                        hc_d = '0;
                        if (idx_q == IDX_LAST) begin
                            rdy_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            csb_d   = 1'b0;
                            state_d = ST_LOAD;
                        end
                    end else begin
                        hc_d = hc_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    rdy_d = 1'b1;
                end
                default: begin
                    state_d = ST_PWR_WAIT;
                end
            endcase
        end
    end

    assign ADC_RDY        = rdy_q;
    assign ADC_CSB        = csb_q;
    assign ADC_SCLK       = sclk_q;
    assign ADC_SDATA      = sdata_q;
    assign ADC_INIT_STATE = state_q;

endmodule

// File: tb/tb_adc_init_seq.sv
// Directed bench for adc_init_seq: full run, frame contents, abort, restart from
// Done, asynchronous reset mid-frame, and a single-word instance.
module tb_adc_init_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic restart = 1'b0;
    logic restart1 = 1'b0;

    logic rdy, csb, sclk, sdata;
    logic [2:0] st;
    logic rdy1, csb1, sclk1, sdata1;
    logic [2:0] st1;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_w [0:3];

    adc_init_seq #(.NWORDS(4), .SCLK_DIV(2), .PWR_DLY(16)) dut (
        .CLK(clk), .ADC_INIT_RST(rst), .RESTART(restart),
        .ADC_RDY(rdy), .ADC_CSB(csb), .ADC_SCLK(sclk), .ADC_SDATA(sdata),
        .ADC_INIT_STATE(st)
    );

    adc_init_seq #(.NWORDS(1), .SCLK_DIV(2), .PWR_DLY(16)) dut1 (
        .CLK(clk), .ADC_INIT_RST(rst), .RESTART(restart1),
        .ADC_RDY(rdy1), .ADC_CSB(csb1), .ADC_SCLK(sclk1), .ADC_SDATA(sdata1),
        .ADC_INIT_STATE(st1)
    );

    always #5 clk = ~clk;

    // Edge number since reset release: after edge k, cyc == k.
    int cyc = 0;
    always @(posedge clk) begin
        if (rst) cyc = 0;
        else cyc = cyc + 1;
    end

    // Bus monitor for the 4-word instance.
    int          fr_bits [$];
    logic [23:0] fr_dat [$];
    int          cur_bits = 0;
    logic [23:0] cur_dat = '0;
    int          since_rise = 100;
    int          since_chg = 100;
    int          stab_bad = 0;
    int          rdy_edge = -1;
    logic        p_csb = 1'b1, p_sclk = 1'b0, p_sdata = 1'b0, p_rdy = 1'b0;

    always @(negedge clk) begin
        since_rise = since_rise + 1;
        since_chg  = since_chg + 1;
        if (!csb && !p_csb && sdata !== p_sdata) begin
            if (since_rise < 2) stab_bad = stab_bad + 1;
            since_chg = 0;
        end
        if (!csb && sclk && !p_sclk) begin
            if (since_chg < 2) stab_bad = stab_bad + 1;
            cur_dat    = {cur_dat[22:0], sdata};
            cur_bits   = cur_bits + 1;
            since_rise = 0;
        end
        if (csb && !p_csb) begin
            fr_bits.push_back(cur_bits);
            fr_dat.push_back(cur_dat);
            cur_bits   = 0;
            cur_dat    = '0;
            since_rise = 100;
        end
        if (rdy && !p_rdy) rdy_edge = cyc;
        p_csb = csb; p_sclk = sclk; p_sdata = sdata; p_rdy = rdy;
    end

    // Lighter monitor for the single-word instance.
    int          f1_cnt = 0;
    logic [23:0] f1_last = '0;
    logic [23:0] c1_dat = '0;
    int          rdy1_edge = -1;
    logic        q_csb1 = 1'b1, q_sclk1 = 1'b0, q_rdy1 = 1'b0;

    always @(negedge clk) begin
        if (!csb1 && sclk1 && !q_sclk1) c1_dat = {c1_dat[22:0], sdata1};
        if (csb1 && !q_csb1) begin
            f1_cnt  = f1_cnt + 1;
            f1_last = c1_dat;
            c1_dat  = '0;
        end
        if (rdy1 && !q_rdy1) rdy1_edge = cyc;
        q_csb1 = csb1; q_sclk1 = sclk1; q_rdy1 = rdy1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rdy(input string tag);
        for (int i = 0; i < 1000 && !rdy; i++) tick();
        chk(tag, {31'd0, rdy}, 32'd1);
    endtask

    task automatic check_frames(input string tag, input int first, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_bits"}, fr_bits[first + i], 32'd24);
            chk({tag, "_data"}, {8'd0, fr_dat[first + i]}, {8'd0, exp_w[i]});
        end
    endtask

    task automatic clear_mon;
        fr_bits.delete();
        fr_dat.delete();
        rdy_edge = -1;
    endtask

    int e;

    initial begin
        exp_w[0] = 24'h000001;
        exp_w[1] = 24'h0D0000;
        exp_w[2] = 24'h140041;
        exp_w[3] = 24'h160080;

        // Reset state
        repeat (3) tick();
        chk("rst_rdy",   {31'd0, rdy},   32'd0);
        chk("rst_csb",   {31'd0, csb},   32'd1);
        chk("rst_sclk",  {31'd0, sclk},  32'd0);
        chk("rst_sdata", {31'd0, sdata}, 32'd0);
        chk("rst_state", {29'd0, st},    32'd0);

        // Full sequence and frame contents
        clear_mon();
        rst = 1'b0;
        wait_rdy("run1_rdy_timeout");
        chk("run1_rdy_edge", rdy_edge, 32'd420);
        chk("run1_nframes", fr_bits.size(), 32'd4);
        if (fr_bits.size() == 4) check_frames("run1", 0, 4);
        chk("run1_state_done", {29'd0, st}, 32'd4);
        chk("n1_rdy_edge", rdy1_edge, 32'd117);
        chk("n1_nframes", f1_cnt, 32'd1);
        chk("n1_word0", {8'd0, f1_last}, {8'd0, exp_w[0]});

        // Restart from Done
        clear_mon();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        e = cyc;
        chk("rs_rdy",   {31'd0, rdy}, 32'd0);
        chk("rs_state", {29'd0, st},  32'd0);
        chk("rs_csb",   {31'd0, csb}, 32'd1);
        wait_rdy("rs_rdy_timeout");
        chk("rs_rdy_edge", rdy_edge, e + 420);
        chk("rs_nframes", fr_bits.size(), 32'd4);
        if (fr_bits.size() == 4) check_frames("rs", 0, 4);

        // Abort during the 10th bit of frame 2
        clear_mon();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 2000 && !(fr_bits.size() == 2 && cur_bits == 10); i++) tick();
        chk("ab_reach_bit10", cur_bits, 32'd10);
        restart = 1'b1;
        tick();
        restart = 1'b0;
        e = cyc;
        chk("ab_csb",  {31'd0, csb},  32'd1);
        chk("ab_sclk", {31'd0, sclk}, 32'd0);
        wait_rdy("ab_rdy_timeout");
        chk("ab_rdy_edge", rdy_edge, e + 420);
        chk("ab_nframes", fr_bits.size(), 32'd7);
        if (fr_bits.size() == 7) begin
            check_frames("ab_pre", 0, 2);
            chk("ab_partial_bits", fr_bits[2], 32'd10);
            check_frames("ab_post", 3, 4);
        end

        // Asynchronous reset mid-shift
        clear_mon();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int i = 0; i < 2000 && !(cur_bits == 5); i++) tick();
        chk("ar_reach_bit5", {29'd0, st}, 32'd2);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_rdy",   {31'd0, rdy},   32'd0);
        chk("ar_csb",   {31'd0, csb},   32'd1);
        chk("ar_sclk",  {31'd0, sclk},  32'd0);
        chk("ar_sdata", {31'd0, sdata}, 32'd0);
        chk("ar_state", {29'd0, st},    32'd0);
        repeat (2) tick();
        clear_mon();
        rst = 1'b0;
        wait_rdy("ar_rdy_timeout");
        chk("ar_rdy_edge", rdy_edge, 32'd420);
        chk("ar_nframes", fr_bits.size(), 32'd4);
        if (fr_bits.size() == 4) check_frames("ar", 0, 4);

        chk("sdata_stability", stab_bad, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
